// File: rtl/alu_shift_pkg.sv
// Shared constants, FSM states and the latched operation descriptor for the
// sequential shift/rotate engine.
package alu_shift_pkg;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic direction;  // 0 = left, 1 = right
    logic rotate;     // 0 = logical shift, 1 = rotate
    logic arith;      // sign-fill on logical right shifts
  } op_t;

endpackage

// File: rtl/shift_step_cell.sv
// Single-bit shift/rotate of one word; purely combinational, zero latency.
module shift_step_cell
  import alu_shift_pkg::*;
(
  input  logic [WIDTH-1:0] Out,
  input  op_t              op,
  output logic [WIDTH-1:0] next,
  output logic             bit_out
);

  logic fill_left;
  logic fill_right;

  always_comb begin
    fill_left  = op.rotate ? Out[WIDTH-1] : 1'b0;
    // arith only matters for logical right shifts; rotate wins otherwise
    fill_right = op.rotate ? Out[0] : (op.arith & Out[WIDTH-1]);
    bit_out    = op.direction ? Out[0] : Out[WIDTH-1];
    next       = op.direction ? {fill_right, Out[WIDTH-1:1]}
                              : {Out[WIDTH-2:0], fill_left};
  end

endmodule

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shifter: one bit per clock, done pulses N cycles after accept; start ignored while busy.
// Optional sign-extending right shift with ALU_SEQ_SHIFTER_ARITH_EN.
module alu_seq_shifter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = alu_shift_pkg::WIDTH,
  parameter int AMT_W = alu_shift_pkg::AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amount,
  input  logic             direction,
  input  logic             rotate,
`ifdef ALU_SEQ_SHIFTER_ARITH_EN
  input  logic             arith,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             carry_out
);

  state_t           state;
  logic [AMT_W-1:0] count;
  op_t              op_in;
  op_t              op_q;
  logic [WIDTH-1:0] step_next;
  logic             step_bit;

  always_comb begin
    op_in           = '0;
    op_in.direction = direction;
    op_in.rotate    = rotate;
`ifdef ALU_SEQ_SHIFTER_ARITH_EN
    op_in.arith     = arith;
`endif
  end

  shift_step_cell u_step (
    .Out     (Out),
    .op      (op_q),
    .next    (step_next),
    .bit_out (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      Out       <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            Out       <= A;
            count     <= amount;
            op_q      <= op_in;
            carry_out <= 1'b0;
            if (amount == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        S_SHIFT: begin
          Out       <= step_next;
          carry_out <= step_bit;
          count     <= count - 1'b1;
          if (count == AMT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Directed bench for alu_seq_shifter with a whole-word arithmetic reference model.
module tb_alu_seq_shifter;

`ifdef ALU_SEQ_SHIFTER_ARITH_EN
  localparam bit ARITH_ON = 1'b1;
`else
  localparam bit ARITH_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = 8'h00;
  logic [2:0] amount = 3'd0;
  logic       direction = 1'b0;
  logic       rotate = 1'b0;
  logic       arith = 1'b0;
  logic       busy, done, carry_out;
  logic [7:0] Out;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .amount    (amount),
    .direction (direction),
    .rotate    (rotate),
`ifdef ALU_SEQ_SHIFTER_ARITH_EN
    .arith     (arith),
`endif
    .busy      (busy),
    .done      (done),
    .Out       (Out),
    .carry_out (carry_out)
  );

  // Result of shifting a by n as one whole-word operation: {carry, result}.
  function automatic logic [8:0] model(input logic [7:0] a, input int n,
                                       input bit dir, input bit rot, input bit ar);
    logic [15:0] w;
    logic [7:0]  r;
    logic        c;
    if (n == 0) return {1'b0, a};
    if (!dir) begin
      w = {8'h00, a} << n;
      r = rot ? (w[7:0] | w[15:8]) : w[7:0];
      c = w[8];
    end else begin
      w = {a, 8'h00} >> n;
      r = rot ? (w[15:8] | w[7:0]) : w[15:8];
      if (!rot && ar && ARITH_ON && a[7]) r = r | ~(8'hFF >> n);
      c = w[7];
    end
    return {c, r};
  endfunction

  int         m_rem;
  logic       m_busy, m_done, m_cy;
  logic [7:0] m_out;
  logic [8:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_out <= 8'h00; m_cy <= 1'b0; m_pend <= 9'h000;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_cy, m_out} <= m_pend;
      end
    end else if (start) begin
      m_pend <= model(A, int'(amount), direction, rotate, arith);
      if (amount == 3'd0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_cy, m_out} <= {1'b0, A};
      end else begin
        m_rem  <= int'(amount);
        m_busy <= 1'b1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; Out/carry are only meaningful when not busy.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        check("cyc_out", 32'(Out), 32'(m_out));
        check("cyc_carry", 32'(carry_out), 32'(m_cy));
      end
    end
  end

  // Called at a negedge; leaves us at the negedge of the cycle after the accept edge.
  task automatic launch(input logic [7:0] a, input logic [2:0] amt,
                        input bit dir, input bit rot, input bit ar);
    A = a; amount = amt; direction = dir; rotate = rot; arith = ar; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done and checks latency, busy length and the final result.
  task automatic await(input string name, input int amt, input int cyc0,
                       input logic [7:0] eo, input bit ec);
    int cyc = cyc0;
    int busy_cnt = cyc0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(amt));
    check({name, "_busy_len"}, 32'(busy_cnt), 32'(amt));
    check({name, "_out"}, 32'(Out), 32'(eo));
    check({name, "_carry"}, 32'(carry_out), 32'(ec));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_out", 32'(Out), 32'h0);
    check("rst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    launch(8'h01, 3'd3, 1'b0, 1'b0, 1'b0);
    await("ll3_01", 3, 0, 8'h08, 1'b0);
    repeat (2) @(negedge clk);

    launch(8'hB3, 3'd3, 1'b1, 1'b1, 1'b0);
    await("rr3_b3", 3, 0, 8'h76, 1'b0);
    launch(8'hB3, 3'd1, 1'b0, 1'b1, 1'b0);
    await("rl1_b3", 1, 0, 8'h67, 1'b1);

    launch(8'hFF, 3'd7, 1'b0, 1'b0, 1'b0);
    await("ll7_ff", 7, 0, 8'h80, 1'b1);
    launch(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
    await("amt0_5a", 0, 0, 8'h5A, 1'b0);
    repeat (2) @(negedge clk);

    launch(8'h0F, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    A = 8'h00; amount = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await("rl4_0f_ignore", 4, 2, 8'h00, 1'b1);
    repeat (3) @(negedge clk);

    launch(8'hF0, 3'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_out", 32'(Out), 32'h0);
    check("midrst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'h0);
    launch(8'h81, 3'd1, 1'b1, 1'b1, 1'b0);
    await("rr1_81", 1, 0, 8'hC0, 1'b1);
    repeat (2) @(negedge clk);

    launch(8'h96, 3'd5, 1'b1, 1'b0, 1'b1);
    await("sr5_96", 5, 0, ARITH_ON ? 8'hFC : 8'h04, 1'b1);
`ifdef ALU_SEQ_SHIFTER_ARITH_EN
    launch(8'h80, 3'd3, 1'b1, 1'b0, 1'b1);
    await("asr3_80", 3, 0, 8'hF0, 1'b0);
    launch(8'h80, 3'd3, 1'b1, 1'b0, 1'b0);
    await("lsr3_80", 3, 0, 8'h10, 1'b0);
    launch(8'h80, 3'd2, 1'b0, 1'b0, 1'b1);
    await("asl2_80", 2, 0, 8'h00, 1'b0);
`endif
    launch(8'hC5, 3'd6, 1'b0, 1'b1, 1'b0);
    await("rl6_c5", 6, 0, 8'h71, 1'b1);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
